// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_pkg
//  Description : Shared types and screen/sprite geometry for the fighter
//                sprite blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package fighter_pkg;

    // Motion state as seen by the renderer and by debug logic
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        AIRBORNE = 2'd2
    } motion_state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SPRITE_W    = 40;
    localparam int SPRITE_H    = 60;
    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

    // ROM word offset of the first pixel of an animation frame
    function automatic logic [13:0] frame_base(input logic [1:0] idx);
        return 14'(idx) * 14'(FRAME_WORDS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vsync_tick.sv
`default_nettype none
// ============================================================================
//  Module      : vsync_tick
//  Description : Turns the active-low vsync pulse into a one-cycle tick at the
//                end of sync, i.e. inside vertical blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsync_tick (
    input  logic vga_clk,
    input  logic reset,
    input  logic i_vs,
    output logic o_tick
);

    logic r_vs_d;

    // Delayed copy of vsync; resets high so no spurious tick leaves reset
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= i_vs;
        end
    end

    assign o_tick = i_vs & ~r_vs_d;

endmodule
`default_nettype wire

// File: rtl/fighter_motion.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_motion
//  Description : Per-frame motion, jump physics and run-cycle animation for
//                one fighter sprite. Everything updates once per vsync tick,
//                so outputs are stable for the whole active frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module fighter_motion
    import fighter_pkg::*;
#(
    parameter int START_X    = 300,
    parameter int GROUND_Y   = 380,
    parameter int RUN_SPEED  = 2,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 12,
    parameter int ANIM_DIV   = 6,
    parameter int NUM_FRAMES = 4
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        vs,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    output logic [9:0]  SpriteX,
    output logic [9:0]  SpriteY,
    output logic        facing_left,
    output logic [1:0]  frame_idx,
    output logic [13:0] rom_base,
    output logic [1:0]  state_o
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [9:0]        c_x_max      = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0]        c_run        = 10'(RUN_SPEED);
    localparam logic [9:0]        c_start_x    = 10'(START_X);
    localparam logic [9:0]        c_ground_y   = 10'(GROUND_Y);
    localparam logic signed [10:0] c_ground_ext = 11'(GROUND_Y);
    localparam logic signed [7:0] c_jump_vel   = 8'(JUMP_VEL);
    localparam logic signed [7:0] c_gravity    = 8'(GRAVITY);
    localparam logic signed [7:0] c_max_fall   = 8'(MAX_FALL);
    localparam logic [CNT_W-1:0]  c_cnt_last   = CNT_W'(ANIM_DIV - 1);
    localparam logic [1:0]        c_frame_last = 2'(NUM_FRAMES - 1);

    motion_state_t     r_state,  w_state_nxt;
    logic [9:0]        r_x,      w_x_nxt;
    logic [9:0]        r_y,      w_y_nxt;
    logic signed [7:0] r_vel,    w_vel_nxt;
    logic              r_face,   w_face_nxt;
    logic [1:0]        r_frame,  w_frame_nxt;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [13:0]       r_rom;
    logic              r_jump_d;
    logic              r_jump_req;

    logic              w_tick;
    logic              w_go_left;
    logic              w_go_right;
    logic              w_moving;
    logic              w_jump_pending;
    logic signed [10:0] w_next_y;
    logic signed [7:0] w_vel_inc;

    vsync_tick u_vsync_tick (
        .vga_clk (vga_clk),
        .reset   (reset),
        .i_vs    (vs),
        .o_tick  (w_tick)
    );

    // Pressing both keys cancels out, same as pressing neither
    assign w_go_left  = move_left & ~move_right;
    assign w_go_right = move_right & ~move_left;
    assign w_moving   = w_go_left | w_go_right;

    // A jump edge coincident with the tick is consumed by that tick
    assign w_jump_pending = r_jump_req | (jump & ~r_jump_d);

    assign w_next_y  = $signed({1'b0, r_y}) + $signed({{3{r_vel[7]}}, r_vel});
    assign w_vel_inc = r_vel + c_gravity;

    // Next-frame position, physics, state and animation
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_vel_nxt   = r_vel;
        w_face_nxt  = r_face;
        w_frame_nxt = r_frame;
        w_cnt_nxt   = r_cnt;

        // Horizontal motion applies in every state, clamped to the screen
        if (w_go_right) begin
            w_face_nxt = 1'b0;
            w_x_nxt    = (r_x >= c_x_max - c_run) ? c_x_max : r_x + c_run;
        end else if (w_go_left) begin
            w_face_nxt = 1'b1;
            w_x_nxt    = (r_x < c_run) ? 10'd0 : r_x - c_run;
        end

        case (r_state)
            IDLE, RUN: begin
                if (w_jump_pending) begin
                    w_state_nxt = AIRBORNE;
                    w_vel_nxt   = -c_jump_vel;
                end else if (w_moving) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            AIRBORNE: begin
                if ((r_vel > 8'sd0) && (w_next_y >= c_ground_ext)) begin
                    w_y_nxt     = c_ground_y;
                    w_vel_nxt   = 8'sd0;
                    w_state_nxt = w_moving ? RUN : IDLE;
                end else if (w_next_y < 11'sd0) begin
                    w_y_nxt   = 10'd0;
                    w_vel_nxt = 8'sd0;
                end else begin
                    w_y_nxt   = w_next_y[9:0];
                    w_vel_nxt = (w_vel_inc > c_max_fall) ? c_max_fall : w_vel_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Animation follows the state being entered this frame
        case (w_state_nxt)
            RUN: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_frame_nxt = (r_frame == c_frame_last) ? 2'd0 : r_frame + 2'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            AIRBORNE: begin
                w_cnt_nxt   = r_cnt;
                w_frame_nxt = r_frame;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_frame_nxt = 2'd0;
            end
        endcase
    end

    // Frame-rate state register plus per-cycle jump edge capture
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_x        <= c_start_x;
            r_y        <= c_ground_y;
            r_vel      <= 8'sd0;
            r_face     <= 1'b0;
            r_frame    <= 2'd0;
            r_cnt      <= '0;
            r_rom      <= 14'd0;
            r_jump_d   <= 1'b0;
            r_jump_req <= 1'b0;
        end else begin
            r_jump_d   <= jump;
            r_jump_req <= w_tick ? 1'b0 : w_jump_pending;
            if (w_tick) begin
                r_state <= w_state_nxt;
                r_x     <= w_x_nxt;
                r_y     <= w_y_nxt;
                r_vel   <= w_vel_nxt;
                r_face  <= w_face_nxt;
                r_frame <= w_frame_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rom   <= frame_base(w_frame_nxt);
            end
        end
    end

    assign SpriteX     = r_x;
    assign SpriteY     = r_y;
    assign facing_left = r_face;
    assign frame_idx   = r_frame;
    assign rom_base    = r_rom;
    assign state_o     = r_state;

endmodule
`default_nettype wire
